mac_seq: RTL and testbench

- Upstream sequencer for the single-lane mac (A/B registered, acc-gated accumulate, format select, sync reset clears psum).
- Accepts a stream of (A,B) operand pairs over a valid/ready handshake and clears the mac before each dot product.
- Aligns mac acc with the mac's internal operand register stage, then captures the finished psum.
- Presents the captured result on a valid/ready output port.

---
 rtl/mac_seq.sv | 136 +++++++++++++
 tb/tb_mac_seq.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq
// Description : Upstream sequencer for a single-lane mac: clears the mac,
//               streams operand pairs, drains the pipeline, holds the result.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_seq #(
    parameter int BW      = 8,
    parameter int PSUM_BW = 16,
    parameter int LEN     = 8,
    parameter int CW      = $clog2(LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_format,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BW-1:0]      in_a,
    input  logic [BW-1:0]      in_b,
    input  logic               in_last,
    output logic [BW-1:0]      mac_a,
    output logic [BW-1:0]      mac_b,
    output logic               mac_acc,
    output logic               mac_format,
    output logic               mac_reset,
    input  logic [PSUM_BW-1:0] mac_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [PSUM_BW-1:0] res_data,
    output logic [CW-1:0]      res_count,
    output logic               res_trunc
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    localparam logic [CW-1:0] C_LEN = CW'(LEN);

    state_t        r_state;
    state_t        w_next;
    logic          r_v1;
    logic [CW-1:0] r_count;
    logic [1:0]    r_drain;

    logic          w_hs;
    logic [CW-1:0] w_cnt_inc;
    logic          w_at_len;
    logic          w_term;

    assign in_ready  = (r_state == S_STREAM);
    assign mac_reset = reset | (r_state == S_CLEAR);

    assign w_hs      = in_valid & in_ready;
    assign w_cnt_inc = r_count + CW'(1);
    assign w_at_len  = (w_cnt_inc == C_LEN);
    assign w_term    = w_hs & (in_last | w_at_len);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_next = S_CLEAR;
            S_CLEAR:  w_next = S_STREAM;
            S_STREAM: if (w_term) w_next = S_DRAIN;
            S_DRAIN:  if (r_drain == 2'd2) w_next = S_HOLD;
            S_HOLD:   if (res_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // v1 marks a pair launched last edge; mac_acc follows it by one edge so the
    // accumulate lines up with the mac's own operand register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_v1       <= 1'b0;
            r_count    <= '0;
            r_drain    <= '0;
            mac_a      <= '0;
            mac_b      <= '0;
            mac_acc    <= 1'b0;
            mac_format <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_count  <= '0;
            res_trunc  <= 1'b0;
        end else begin
            r_state <= w_next;
            mac_acc <= r_v1;
            r_v1    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        mac_format <= cfg_format;
                        r_count    <= '0;
                    end
                end
                S_CLEAR: r_drain <= '0;
                S_STREAM: begin
                    if (w_hs) begin
                        mac_a   <= in_a;
                        mac_b   <= in_b;
                        r_v1    <= 1'b1;
                        r_count <= w_cnt_inc;
                        if (w_term) begin
                            res_trunc <= w_at_len & ~in_last;
                            r_drain   <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    r_drain <= r_drain + 2'd1;
                    if (r_drain == 2'd2) begin
                        res_data  <= mac_out;
                        res_count <= r_count;
                        res_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_trunc <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_seq
// Description : Self-checking bench for mac_seq with a behavioural mac and a
//               dot-product reference computed directly from operand lists.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_format;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_last;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic        mac_acc;
    logic        mac_format;
    logic        mac_reset;
    logic [15:0] mac_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [3:0]  res_count;
    logic        res_trunc;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int hs_cyc   = 0;
    int res_cyc  = 0;
    bit tmo      = 1'b0;

    mac_seq dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_format (cfg_format),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_acc    (mac_acc),
        .mac_format (mac_format),
        .mac_reset  (mac_reset),
        .mac_out    (mac_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_count  (res_count),
        .res_trunc  (res_trunc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Operand / result value helpers (format 0 = 2's complement, 1 = sign-magnitude)
    function automatic int op_val(input logic [7:0] v, input logic fmt);
        if (fmt) return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
        return int'($signed(v));
    endfunction

    function automatic int psum_val(input logic [15:0] v, input logic fmt);
        if (fmt) return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
        return int'($signed(v));
    endfunction

    function automatic logic [15:0] enc(input int s, input logic fmt);
        int m;
        if (!fmt) return s[15:0];
        m = (s < 0) ? -s : s;
        return {(s < 0), m[14:0]};
    endfunction

    // Behavioural single-lane mac: registered operands, acc-gated accumulate.
    logic [7:0]  m_a, m_b;
    logic [15:0] m_psum;
    assign mac_out = m_psum;
    always @(posedge clk) begin
        if (mac_reset) begin
            m_a <= '0; m_b <= '0; m_psum <= '0;
        end else begin
            m_a <= mac_a;
            m_b <= mac_b;
            if (mac_acc)
                m_psum <= enc(psum_val(m_psum, mac_format)
                              + op_val(m_a, mac_format) * op_val(m_b, mac_format), mac_format);
        end
    end

    int   acc_hi = 0, acc_rise = 0, mrst_hi = 0;
    logic acc_prev = 1'b0;
    always @(negedge clk) begin
        if (mac_acc) acc_hi++;
        if (mac_acc && !acc_prev) acc_rise++;
        acc_prev = mac_acc;
        if (mac_reset && !reset) mrst_hi++;
    end

    // Present one pair (called at a negedge); returns at the negedge after handshake.
    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last,
                             input int bubbles);
        int w;
        w = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        while (!in_ready && w < 40) begin
            @(negedge clk); w++;
        end
        if (!in_ready) begin
            tmo = 1'b1; in_valid = 1'b0; in_last = 1'b0;
            return;
        end
        @(negedge clk);
        hs_cyc = cyc; in_valid = 1'b0; in_last = 1'b0;
        repeat (bubbles) @(negedge clk);
    endtask

    task automatic wait_result();
        int w;
        w = 0;
        while (!res_valid && w < 60) begin
            @(negedge clk); w++;
        end
        if (!res_valid) tmo = 1'b1;
        res_cyc = cyc;
    endtask

    task automatic ack();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_format = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_last = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, res_valid, res_trunc, mac_acc, mac_format} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000",
                     {in_ready, res_valid, res_trunc, mac_acc, mac_format});
        else n_pass++;
        n_checks++;
        if ({mac_a, mac_b, res_data, res_count} !== 36'h0)
            $display("FAIL reset_data: got %h want 0", {mac_a, mac_b, res_data, res_count});
        else n_pass++;
        n_checks++;
        if (mac_reset !== 1'b1) $display("FAIL reset_fwd: got %b want 1", mac_reset);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mac_reset, in_ready} !== 2'b00)
            $display("FAIL idle_after_reset: got %b want 00", {mac_reset, in_ready});
        else n_pass++;
    endtask

    task automatic test_twos_comp();
        cfg_format = 1'b0;
        send_pair(8'd3, 8'd4, 1'b0, 0);
        send_pair(8'hFE, 8'd7, 1'b0, 0);
        send_pair(8'd5, 8'hFF, 1'b1, 0);
        wait_result();
        n_checks++;
        if (tmo !== 1'b0) $display("FAIL t1_timeout: got %b want 0", tmo); else n_pass++;
        n_checks++;
        if (res_data !== 16'hFFF9) $display("FAIL t1_data: got %h want fff9", res_data);
        else n_pass++;
        n_checks++;
        if (res_count !== 4'd3 || res_trunc !== 1'b0)
            $display("FAIL t1_count_trunc: got %0d/%b want 3/0", res_count, res_trunc);
        else n_pass++;
        n_checks++;
        if (res_cyc - hs_cyc !== 3)
            $display("FAIL t1_latency: got %0d want 3", res_cyc - hs_cyc);
        else n_pass++;
        ack();
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL t1_drop: got %b want 0", res_valid);
        else n_pass++;
    endtask

    task automatic test_sign_mag();
        cfg_format = 1'b1;
        send_pair(8'h83, 8'h02, 1'b1, 0);
        n_checks++;
        if (mac_format !== 1'b1) $display("FAIL t2_format: got %b want 1", mac_format);
        else n_pass++;
        wait_result();
        n_checks++;
        if (res_data !== 16'h8006) $display("FAIL t2_neg: got %h want 8006", res_data);
        else n_pass++;
        ack();
        send_pair(8'h03, 8'h02, 1'b1, 0);
        wait_result();
        n_checks++;
        if (res_data !== 16'h0006) $display("FAIL t2_pos: got %h want 0006", res_data);
        else n_pass++;
        ack();
    endtask

    task automatic test_bubbles();
        int a0, r0;
        cfg_format = 1'b0;
        a0 = acc_hi; r0 = acc_rise;
        send_pair(8'd3, 8'd4, 1'b0, 2);
        send_pair(8'hFE, 8'd7, 1'b0, 2);
        send_pair(8'd5, 8'hFF, 1'b1, 0);
        wait_result();
        n_checks++;
        if (res_data !== 16'hFFF9 || res_count !== 4'd3)
            $display("FAIL t3_result: got %h/%0d want fff9/3", res_data, res_count);
        else n_pass++;
        n_checks++;
        if (acc_hi - a0 !== 3 || acc_rise - r0 !== 3)
            $display("FAIL t3_acc_pulses: got %0d high/%0d rises want 3/3",
                     acc_hi - a0, acc_rise - r0);
        else n_pass++;
        ack();
    endtask

    task automatic test_len_limit();
        int m0;
        cfg_format = 1'b0;
        m0 = mrst_hi;
        for (int i = 0; i < 8; i++) send_pair(8'd1, 8'd1, 1'b0, 0);
        fork
            send_pair(8'd1, 8'd1, 1'b0, 0);
            begin
                wait_result();
                n_checks++;
                if (res_data !== 16'h0008 || res_count !== 4'd8 || res_trunc !== 1'b1)
                    $display("FAIL t4_first: got %h/%0d/%b want 0008/8/1",
                             res_data, res_count, res_trunc);
                else n_pass++;
                ack();
            end
        join
        send_pair(8'd1, 8'd1, 1'b1, 0);
        wait_result();
        n_checks++;
        if (res_data !== 16'h0002 || res_count !== 4'd2 || res_trunc !== 1'b0)
            $display("FAIL t4_second: got %h/%0d/%b want 0002/2/0",
                     res_data, res_count, res_trunc);
        else n_pass++;
        n_checks++;
        if (mrst_hi - m0 !== 2) $display("FAIL t4_mac_reset: got %0d want 2", mrst_hi - m0);
        else n_pass++;
        ack();
    endtask

    task automatic test_backpressure();
        cfg_format = 1'b0;
        send_pair(8'd5, 8'd6, 1'b1, 0);
        wait_result();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== 16'h001E || res_count !== 4'd1 || in_ready !== 1'b0)
                $display("FAIL t5_hold: got v=%b d=%h c=%0d r=%b want 1/001e/1/0",
                         res_valid, res_data, res_count, in_ready);
            else n_pass++;
        end
        ack();
        n_checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL t5_release: got v=%b r=%b want 0/0", res_valid, in_ready);
        else n_pass++;
        send_pair(8'd7, 8'hFD, 1'b1, 0);
        wait_result();
        n_checks++;
        if (res_data !== 16'hFFEB) $display("FAIL t5_next: got %h want ffeb", res_data);
        else n_pass++;
        ack();
    endtask

    task automatic test_reset_mid();
        cfg_format = 1'b1;
        send_pair(8'd9, 8'd9, 1'b0, 0);
        send_pair(8'd4, 8'd4, 1'b0, 0);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, res_valid, res_trunc, mac_acc, mac_format} !== 5'b0 ||
            {mac_a, mac_b, res_data, res_count} !== 36'h0)
            $display("FAIL t6_reset_state: got %b %h want all 0",
                     {in_ready, res_valid, res_trunc, mac_acc, mac_format},
                     {mac_a, mac_b, res_data, res_count});
        else n_pass++;
        reset = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL t6_no_result: got %b want 0", res_valid);
        else n_pass++;
        cfg_format = 1'b0;
        send_pair(8'd2, 8'd3, 1'b1, 0);
        wait_result();
        n_checks++;
        if (res_data !== 16'h0006 || res_count !== 4'd1)
            $display("FAIL t6_fresh_op: got %h/%0d want 0006/1", res_data, res_count);
        else n_pass++;
        ack();
    endtask

    // Random dot products; cfg_format is flipped mid-op and must be ignored.
    task automatic test_random();
        logic        fmt;
        logic [7:0]  a, b;
        int          n, sum, a0;
        logic [15:0] exp_data;
        for (int op = 0; op < 25; op++) begin
            fmt = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 8);
            sum = 0;
            cfg_format = fmt;
            a0 = acc_hi;
            for (int i = 0; i < n; i++) begin
                if (fmt) begin
                    a = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 63))};
                    b = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 63))};
                end else begin
                    a = 8'($urandom);
                    b = 8'($urandom);
                end
                sum += op_val(a, fmt) * op_val(b, fmt);
                send_pair(a, b, (i == n - 1), (i == n - 1) ? 0 : int'($urandom_range(0, 2)));
                cfg_format = ~fmt;
            end
            exp_data = enc(sum, fmt);
            wait_result();
            n_checks++;
            if (res_data !== exp_data || res_count !== 4'(n) || res_trunc !== 1'b0)
                $display("FAIL rnd_op%0d: got %h/%0d/%b want %h/%0d/0",
                         op, res_data, res_count, res_trunc, exp_data, n);
            else n_pass++;
            n_checks++;
            if (res_cyc - hs_cyc !== 3 || acc_hi - a0 !== n)
                $display("FAIL rnd_timing%0d: got lat %0d acc %0d want 3/%0d",
                         op, res_cyc - hs_cyc, acc_hi - a0, n);
            else n_pass++;
            ack();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_twos_comp();
        test_sign_mag();
        test_bubbles();
        test_len_limit();
        test_backpressure();
        test_reset_mid();
        test_random();
        n_checks++;
        if (tmo !== 1'b0) $display("FAIL handshake_timeout: got %b want 0", tmo);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
